// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared states, segment codes and limits for the hex display
package calc_pkg;

  localparam int WIDTH   = 20;
  localparam int DIGITS  = 6;
  localparam int MAX_VAL = 999999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } disp_state_t;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-low seven-segment pattern
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; non-decimal codes show dark
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_hex_display.sv
// rtl/cnt_hex_display.sv - sequential binary-to-BCD conversion driving six hex displays
module cnt_hex_display #(
  parameter int WIDTH   = calc_pkg::WIDTH,
  parameter int DIGITS  = calc_pkg::DIGITS,
  parameter int MAX_VAL = calc_pkg::MAX_VAL
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  logic             blank,
  output logic             busy,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  import calc_pkg::*;

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  disp_state_t       state, state_next;
  logic [WIDTH-1:0]  last_val;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic [CW-1:0]     bitcnt;
  logic              ovf;
  logic              start;
  logic              lead;
  logic [6:0]        seg_raw  [DIGITS];
  logic [6:0]        seg_next [DIGITS];
  logic [6:0]        hex_q    [DIGITS];

  assign start = (cnt != last_val);
  assign busy  = (state != IDLE);

  // State register; reset aborts any conversion in flight
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: capture on mismatch, WIDTH shift steps, one load cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (bitcnt == CW'(WIDTH - 1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would overflow when doubled
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (bcd[4*g +: 4]),
      .seg (seg_raw[g])
    );
  end

  // Final digit patterns: overflow dashes, else blank zeros above the top nonzero digit
  always_comb begin
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seg_next[i] = seg_raw[i];
      if (ovf) begin
        seg_next[i] = SEG_DASH;
      end else if (lead && (bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
        seg_next[i] = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // Conversion datapath and display registers; displays change only in LOAD
  always_ff @(posedge CLK) begin
    if (reset) begin
      last_val <= '0;
      shreg    <= '0;
      bcd      <= '0;
      bitcnt   <= '0;
      ovf      <= 1'b0;
      for (int i = 0; i < DIGITS; i++) hex_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_val <= cnt;
            shreg    <= cnt;
            bcd      <= '0;
            bitcnt   <= '0;
            ovf      <= (cnt > WIDTH'(MAX_VAL));
          end
        end
        CONV: begin
          {bcd, shreg} <= {bcd_adj[BW-2:0], shreg, 1'b0};
          bitcnt       <= bitcnt + 1'b1;
        end
        LOAD: begin
          for (int i = 0; i < DIGITS; i++) hex_q[i] <= seg_next[i];
        end
        default: ;
      endcase
    end
  end

  assign HEX0 = blank ? SEG_BLANK : hex_q[0];
  assign HEX1 = blank ? SEG_BLANK : hex_q[1];
  assign HEX2 = blank ? SEG_BLANK : hex_q[2];
  assign HEX3 = blank ? SEG_BLANK : hex_q[3];
  assign HEX4 = blank ? SEG_BLANK : hex_q[4];
  assign HEX5 = blank ? SEG_BLANK : hex_q[5];

endmodule

// File: tb/tb_cnt_hex_display.sv
// tb/tb_cnt_hex_display.sv - self-checking bench for cnt_hex_display
module tb_cnt_hex_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic [19:0] cnt;
    logic [41:0] hex;
  } vec_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic        blank;
  logic [19:0] cnt;
  logic        busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [41:0] sb_q [$];
  vec_t        tbl [9];
  logic [41:0] hex_all;

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  cnt_hex_display dut (
    .CLK   (CLK),
    .reset (reset),
    .cnt   (cnt),
    .blank (blank),
    .busy  (busy),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Next edge captures cnt; follows the conversion to its end
  task automatic run_conv(input string name, input bit do_pop);
    logic [41:0] prev;
    int          lat;
    bit          stable;
    prev   = hex_all;
    stable = 1'b1;
    step();
    check({name, "_busy"}, 42'(busy), 42'd1);
    lat = 0;
    while (busy && lat < 100) begin
      if (hex_all !== prev) stable = 1'b0;
      step();
      lat++;
    end
    check({name, "_latency"}, 42'(lat), 42'd21);
    check({name, "_stable"}, 42'(stable), 42'd1);
    if (do_pop) check(name, hex_all, sb_q.pop_front());
  endtask

  initial begin
    int  fall_at [2];
    int  falls;
    bit  pb;
    bit  idle_ok;

    tbl[0] = '{20'd123456,  {S1, S2, S3, S4, S5, S6}};
    tbl[1] = '{20'd507,     {SB, SB, SB, S5, S0, S7}};
    tbl[2] = '{20'd0,       {SB, SB, SB, SB, SB, S0}};
    tbl[3] = '{20'd1000000, {SD, SD, SD, SD, SD, SD}};
    tbl[4] = '{20'hFFFFF,   {SD, SD, SD, SD, SD, SD}};
    tbl[5] = '{20'd999999,  {S9, S9, S9, S9, S9, S9}};
    tbl[6] = '{20'd1,       {SB, SB, SB, SB, SB, S1}};
    tbl[7] = '{20'd100000,  {S1, S0, S0, S0, S0, S0}};
    tbl[8] = '{20'd10,      {SB, SB, SB, SB, S1, S0}};

    reset = 1'b1;
    blank = 1'b0;
    cnt   = 20'd0;
    step();
    step();
    check("reset_hex", hex_all, {SB, SB, SB, SB, SB, S0});
    check("reset_busy", 42'(busy), 42'd0);
    reset   = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_zero_no_conv", 42'(idle_ok), 42'd1);

    for (int i = 0; i < 9; i++) begin
      cnt = tbl[i].cnt;
      sb_q.push_back(tbl[i].hex);
      run_conv($sformatf("vec%0d", i), 1'b1);
    end

    // Value changes five cycles into a conversion
    cnt = 20'd100;
    sb_q.push_back({SB, SB, SB, S1, S0, S0});
    fall_at = '{0, 0};
    falls   = 0;
    pb      = busy;
    for (int n = 0; n < 60 && falls < 2; n++) begin
      step();
      if (n == 5) begin
        cnt = 20'd250;
        sb_q.push_back({SB, SB, SB, S2, S5, S0});
      end
      if (pb && !busy) begin
        fall_at[falls] = n;
        check($sformatf("midchg_hex%0d", falls), hex_all, sb_q.pop_front());
        falls++;
      end
      pb = busy;
    end
    check("midchg_first_done", 42'(fall_at[0]), 42'd21);
    check("midchg_second_done", 42'(fall_at[1]), 42'd43);

    // Reset pulse in the middle of converting 999999
    cnt = 20'd999999;
    step();
    for (int i = 0; i < 6; i++) step();
    check("abort_busy_before", 42'(busy), 42'd1);
    reset = 1'b1;
    step();
    check("abort_hex", hex_all, {SB, SB, SB, SB, SB, S0});
    check("abort_busy", 42'(busy), 42'd0);
    reset = 1'b0;
    sb_q.push_back({S9, S9, S9, S9, S9, S9});
    run_conv("reconv", 1'b1);

    // Blank masks the outputs while conversion carries on
    blank = 1'b1;
    #1;
    check("blank_static", hex_all, {42{1'b1}});
    cnt = 20'd5;
    sb_q.push_back({SB, SB, SB, SB, SB, S5});
    run_conv("blank_conv", 1'b0);
    check("blank_after", hex_all, {42{1'b1}});
    blank = 1'b0;
    #1;
    check("unblank", hex_all, sb_q.pop_front());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
